// File: rtl/btb_assoc.sv
// btb_assoc -- set-associative branch target buffer with tree-PLRU replacement.
//
// Ports:
//   clk, rst        : clock; synchronous active-high reset (clears valid and PLRU bits)
//   lookup_valid    : fetch stage presents lookup_pc; a hit then touches the hit way
//   lookup_pc[31:0] : fetch PC; hit/target/br_type are a zero-latency read of it
//   hit             : lookup_pc matches a valid entry
//   target[31:0]    : stored target of the hit entry (0 on a miss)
//   br_type[1:0]    : stored type of the hit entry (00 br, 01 jal, 10 jalr; 00 on a miss)
//   update_valid    : write/allocate the entry for update_pc this cycle
//   update_pc       : PC of the resolved control-flow instruction
//   update_target   : resolved target
//   update_type     : resolved type (11 is stored as given)
//   flush           : invalidate every entry and clear PLRU state
//
// Handshake: there is no backpressure. lookup_valid and update_valid are
// qualifiers that are always accepted on the rising edge where they are high;
// the lookup outputs are a pure combinational read of registered state and do
// not depend on lookup_valid. Updates become visible to lookups one cycle later.
//
// Index is pc[S_INDEX+1:2], tag is pc[31:S_INDEX+2]. PLRU nodes are stored in
// heap order (node 0 is the root, children of n are 2n+1 and 2n+2). A node bit
// of 0 points the victim to the lower half, 1 to the upper half.
module btb_assoc #(
   parameter int S_INDEX = 4,
   parameter int WAYS    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        lookup_valid,
   input  logic [31:0] lookup_pc,
   output logic        hit,
   output logic [31:0] target,
   output logic [1:0]  br_type,
   input  logic        update_valid,
   input  logic [31:0] update_pc,
   input  logic [31:0] update_target,
   input  logic [1:0]  update_type,
   input  logic        flush
);

   localparam int SETS  = 1 << S_INDEX;
   localparam int TW    = 30 - S_INDEX;
   localparam int LOG2W = (WAYS > 1) ? $clog2(WAYS) : 0;
   localparam int NODES = WAYS - 1;
   localparam int PW    = (WAYS > 1) ? WAYS - 1 : 1;

   logic          valid_q [SETS][WAYS];
   logic          valid_d [SETS][WAYS];
   logic [TW-1:0] tag_q   [SETS][WAYS];
   logic [TW-1:0] tag_d   [SETS][WAYS];
   logic [31:0]   tgt_q   [SETS][WAYS];
   logic [31:0]   tgt_d   [SETS][WAYS];
   logic [1:0]    btype_q [SETS][WAYS];
   logic [1:0]    btype_d [SETS][WAYS];
   logic [PW-1:0] plru_q  [SETS];
   logic [PW-1:0] plru_d  [SETS];

   logic [S_INDEX-1:0] l_idx, u_idx;
   logic [TW-1:0]      l_tag, u_tag;
   int                 l_way, u_way, inv_way;
   logic               u_hit, u_inv;
   logic [PW-1:0]      plru_look;

   // Low PC bits address bytes inside an instruction and are deliberately ignored.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{lookup_pc[1:0], update_pc[1:0]};

   assign l_idx = lookup_pc[S_INDEX+1:2];
   assign l_tag = lookup_pc[31:S_INDEX+2];
   assign u_idx = update_pc[S_INDEX+1:2];
   assign u_tag = update_pc[31:S_INDEX+2];

   // Depth of heap node j (root is depth 0).
   function automatic int node_level(input int j);
      int l;
      l = 0;
      for (int k = 1; k < 4; k++) begin
         if (j >= (1 << k) - 1) l = k;
      end
      return l;
   endfunction

   // True when node j lies on the root-to-leaf path of way w.
   function automatic logic on_path(input int j, input int w);
      int l;
      l = node_level(j);
      return (w >> (LOG2W - l)) == (j + 1 - (1 << l));
   endfunction

   // Direction way w takes at node j: 0 = lower child, 1 = upper child.
   function automatic logic dir_bit(input int j, input int w);
      int l;
      l = node_level(j);
      return ((w >> (LOG2W - l - 1)) & 1) != 0;
   endfunction

   // Point every node on way w's path away from w.
   function automatic logic [PW-1:0] plru_touch(input logic [PW-1:0] bits, input int w);
      logic [PW-1:0] r;
      r = bits;
      for (int j = 0; j < NODES; j++) begin
         if (on_path(j, w)) r[j] = ~dir_bit(j, w);
      end
      return r;
   endfunction

   // The victim is the one way whose whole path the node bits point toward.
   function automatic int plru_victim(input logic [PW-1:0] bits);
      int   v;
      logic ok;
      v = 0;
      for (int w = 0; w < WAYS; w++) begin
         ok = 1'b1;
         for (int j = 0; j < NODES; j++) begin
            if (on_path(j, w) && (bits[j] != dir_bit(j, w))) ok = 1'b0;
         end
         if (ok) v = w;
      end
      return v;
   endfunction

   // Lookup read port.
   always_comb begin
      hit     = 1'b0;
      target  = '0;
      br_type = '0;
      l_way   = 0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[l_idx][w] && (tag_q[l_idx][w] == l_tag)) begin
            hit     = 1'b1;
            target  = tgt_q[l_idx][w];
            br_type = btype_q[l_idx][w];
            l_way   = w;
         end
      end
   end

   // Update way selection: existing entry, else lowest invalid way, else PLRU victim.
   // The victim is chosen from the set's PLRU state after any same-cycle lookup
   // touch, so the lookup-then-update ordering is consistent end to end.
   always_comb begin
      u_hit   = 1'b0;
      u_inv   = 1'b0;
      inv_way = 0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[u_idx][w] && (tag_q[u_idx][w] == u_tag)) u_hit = 1'b1;
      end
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_q[u_idx][w]) begin
            u_inv   = 1'b1;
            inv_way = w;
         end
      end
      if (lookup_valid && hit && (l_idx == u_idx)) plru_look = plru_touch(plru_q[u_idx], l_way);
      else                                        plru_look = plru_q[u_idx];
      u_way = u_inv ? inv_way : plru_victim(plru_look);
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[u_idx][w] && (tag_q[u_idx][w] == u_tag)) u_way = w;
      end
   end

   // Next-state: flush wins over touch and update.
   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      tgt_d   = tgt_q;
      btype_d = btype_q;
      plru_d  = plru_q;
      if (flush) begin
         for (int s = 0; s < SETS; s++) begin
            plru_d[s] = '0;
            for (int w = 0; w < WAYS; w++) valid_d[s][w] = 1'b0;
         end
      end else begin
         if (lookup_valid && hit) plru_d[l_idx] = plru_touch(plru_q[l_idx], l_way);
         if (update_valid) begin
            plru_d[u_idx] = plru_touch(plru_look, u_way);
            for (int w = 0; w < WAYS; w++) begin
               if (w == u_way) begin
                  valid_d[u_idx][w] = 1'b1;
                  tag_d[u_idx][w]   = u_tag;
                  tgt_d[u_idx][w]   = update_target;
                  btype_d[u_idx][w] = update_type;
               end
            end
         end
      end
   end

   // Reset clears only valid and PLRU state; payload storage is don't-care while invalid.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < SETS; s++) begin
            plru_q[s] <= '0;
            for (int w = 0; w < WAYS; w++) valid_q[s][w] <= 1'b0;
         end
      end else begin
         valid_q <= valid_d;
         tag_q   <= tag_d;
         tgt_q   <= tgt_d;
         btype_q <= btype_d;
         plru_q  <= plru_d;
      end
   end

endmodule

// File: tb/tb_btb_assoc.sv
// tb_btb_assoc -- directed bench for btb_assoc (S_INDEX=4, WAYS=2).
// Driver tasks queue expected lookup results; a negedge monitor pops and compares.
module tb_btb_assoc;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        lookup_valid = 1'b0;
   logic [31:0] lookup_pc = '0;
   logic        hit;
   logic [31:0] target;
   logic [1:0]  br_type;
   logic        update_valid = 1'b0;
   logic [31:0] update_pc = '0;
   logic [31:0] update_target = '0;
   logic [1:0]  update_type = '0;
   logic        flush = 1'b0;

   logic        chk = 1'b0;
   logic [34:0] exp_q[$];
   string       name_q[$];
   logic [34:0] exp_v;
   string       exp_name;
   int          errors = 0;
   int          checks = 0;

   btb_assoc #(.S_INDEX(4), .WAYS(2)) dut (
      .clk(clk), .rst(rst),
      .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
      .hit(hit), .target(target), .br_type(br_type),
      .update_valid(update_valid), .update_pc(update_pc),
      .update_target(update_target), .update_type(update_type),
      .flush(flush)
   );

   // Clock / reset
   always #5 clk = ~clk;

   // Driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
      chk          = 1'b0;
      rst          = 1'b0;
      flush        = 1'b0;
      lookup_valid = 1'b0;
      update_valid = 1'b0;
   endtask

   task automatic look(input logic [31:0] pc, input logic lv, input logic eh,
                       input logic [31:0] et, input logic [1:0] ety, input string nm);
      lookup_pc    = pc;
      lookup_valid = lv;
      chk          = 1'b1;
      exp_q.push_back({eh, et, ety});
      name_q.push_back(nm);
   endtask

   task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic [1:0] ty);
      update_valid  = 1'b1;
      update_pc     = pc;
      update_target = tgt;
      update_type   = ty;
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (chk) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_underflow: got hit=%0b target=%h type=%b, nothing expected",
                     hit, target, br_type);
         end else begin
            exp_v    = exp_q.pop_front();
            exp_name = name_q.pop_front();
            if ({hit, target, br_type} !== exp_v) begin
               errors++;
               $display("FAIL %s: got hit=%0b target=%h type=%b, expected hit=%0b target=%h type=%b",
                        exp_name, hit, target, br_type, exp_v[34], exp_v[33:2], exp_v[1:0]);
            end
         end
      end
   end

   initial begin
      tick();  // reset cycle

      // Cold start
      look(32'h40, 1'b0, 1'b0, 32'h0, 2'b00, "cold_miss");
      tick();

      // Write then read, no same-cycle bypass
      upd(32'h40, 32'h100, 2'b01);
      look(32'h40, 1'b1, 1'b0, 32'h0, 2'b00, "no_bypass");
      tick();
      look(32'h40, 1'b1, 1'b1, 32'h100, 2'b01, "write_read");
      tick();

      // Conflict eviction in set 0: the lookup touch of 0x40 makes 0x80 the victim
      upd(32'h80, 32'h180, 2'b00);
      tick();
      look(32'h40, 1'b1, 1'b1, 32'h100, 2'b01, "touch_0x40");
      tick();
      upd(32'hC0, 32'h300, 2'b10);
      tick();
      look(32'h40, 1'b0, 1'b1, 32'h100, 2'b01, "evict_keep_0x40");
      tick();
      look(32'hC0, 1'b0, 1'b1, 32'h300, 2'b10, "evict_new_0xC0");
      tick();
      look(32'h80, 1'b0, 1'b0, 32'h0, 2'b00, "evict_gone_0x80");
      tick();
      look(32'h43, 1'b0, 1'b1, 32'h100, 2'b01, "low_bits_ignored");
      tick();
      look(32'h44, 1'b0, 1'b0, 32'h0, 2'b00, "other_set_miss");
      tick();

      // Re-update of a present entry
      rst = 1'b1;
      tick();
      upd(32'h40, 32'h100, 2'b01);
      tick();
      upd(32'h80, 32'h180, 2'b00);
      tick();
      upd(32'h40, 32'h200, 2'b10);
      tick();
      look(32'h40, 1'b0, 1'b1, 32'h200, 2'b10, "reupd_new_target");
      tick();
      look(32'h80, 1'b0, 1'b1, 32'h180, 2'b00, "reupd_other_kept");
      tick();
      upd(32'hC0, 32'h340, 2'b11);
      tick();
      look(32'h80, 1'b0, 1'b0, 32'h0, 2'b00, "reupd_evict_0x80");
      tick();
      look(32'h40, 1'b0, 1'b1, 32'h200, 2'b10, "reupd_keep_0x40");
      tick();
      look(32'hC0, 1'b0, 1'b1, 32'h340, 2'b11, "reserved_type");
      tick();

      // Flush with coincident update; outputs still show pre-flush state
      rst = 1'b1;
      tick();
      upd(32'h40, 32'h100, 2'b01);
      tick();
      flush = 1'b1;
      upd(32'h80, 32'h180, 2'b00);
      look(32'h40, 1'b1, 1'b1, 32'h100, 2'b01, "flush_cycle_preview");
      tick();
      look(32'h40, 1'b0, 1'b0, 32'h0, 2'b00, "flush_0x40");
      tick();
      look(32'h80, 1'b0, 1'b0, 32'h0, 2'b00, "flush_0x80");
      tick();

      // Reset mid-operation with coincident update
      upd(32'h40, 32'h100, 2'b01);
      tick();
      rst = 1'b1;
      upd(32'h44, 32'h600, 2'b01);
      tick();
      look(32'h40, 1'b0, 1'b0, 32'h0, 2'b00, "rst_0x40");
      tick();
      look(32'h44, 1'b0, 1'b0, 32'h0, 2'b00, "rst_0x44");
      tick();
      upd(32'h44, 32'h700, 2'b00);
      tick();
      upd(32'h84, 32'h780, 2'b01);
      tick();
      upd(32'hC4, 32'h7C0, 2'b10);
      tick();
      look(32'h44, 1'b0, 1'b0, 32'h0, 2'b00, "rst_plru_evict_0x44");
      tick();
      look(32'h84, 1'b0, 1'b1, 32'h780, 2'b01, "rst_plru_keep_0x84");
      tick();
      look(32'hC4, 1'b0, 1'b1, 32'h7C0, 2'b10, "rst_plru_new_0xC4");
      tick();

      tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
